gray_frame_seq: RTL and testbench
=================================

// Module: gray_frame_seq
// PURPOSE
//  Frame sequencer for the RGB-to-gray datapath. On start it issues one pixel address
//  per cycle to the R/G/B picture ROMs and qualifies the gray converter. It delay-matches
//  the ROM + converter latency and writes each gray pixel to the output frame buffer.
//  It signals end-of-frame and replaces the free-running address counter in the top level.
// PARAMETERS
//  DATAWIDTH   8       pixel / gray sample width
//  ADDRWIDTH   18      pixel address width
//  NUM_PIXELS  262144  pixels per frame (512x512); 1..2**ADDRWIDTH
//  ROM_LAT     1       picture ROM read latency, cycles (>=1)
//  CONV_LAT    1       rgb2gray latency, cycles (>=1); L = ROM_LAT+CONV_LAT
// PORTS
//  CLK         in   1                    clock, rising edge
//  RSTn        in   1                    asynchronous reset, active low
//  start       in   1                    frame request, sampled in IDLE only
//  abort       in   1                    synchronous frame cancel
//  out_ready   in   1                    frame buffer can accept; low = hold
//  rom_addr    out  ADDRWIDTH            address to R/G/B ROMs
//  conv_en     out  1                    converter advance enable (= not held)
//  gray_in     in   DATAWIDTH            gray sample from converter
//  wr_en       out  1                    frame buffer write strobe
//  wr_addr     out  ADDRWIDTH            frame buffer write address
//  wr_data     out  DATAWIDTH            frame buffer write data
//  busy        out  1                    high in RUN/DRAIN/DONE
//  frame_done  out  1                    one-cycle pulse, frame fully written
//  frame_sum   out  DATAWIDTH+ADDRWIDTH  sum of written gray pixels (GRAY_SUM_EN only)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0, including rom_addr, wr_addr, wr_data and frame_sum.
//    The valid pipeline is cleared.
//  - FSM IDLE->RUN on start; rom_addr=0 on entry.
//  - RUN: each cycle with out_ready=1 issues rom_addr and pushes valid=1 into an
//    L-stage shift register, then increments rom_addr.
//  - After address NUM_PIXELS-1 is issued: RUN->DRAIN.
//  - DRAIN: waits until the valid pipeline and the output register are empty, then -> DONE.
//  - DONE: frame_done=1 for one cycle -> IDLE. start is ignored in RUN/DRAIN/DONE.
//  - Timing: address issued in cycle k gives gray_in valid in cycle k+L.
//    wr_en/wr_addr/wr_data are registered and valid in cycle k+L+1.
//  - Writes are strictly ascending from wr_addr 0; wr_addr increments after each write.
//  - Hold: with out_ready=0 sampled at an edge, rom_addr, the valid pipe and the write counter
//    freeze, and conv_en=0 that cycle. wr_en is 0 in the following cycle.
//    One write may appear in the cycle out_ready first drops; the buffer accepts it.
//  - No pixel is dropped or duplicated across any hold pattern.
//  - abort (any state except IDLE): next cycle IDLE, busy=0, valid pipe cleared, wr_en=0,
//    no frame_done. abort has priority over hold and start.
//  - Back-to-back: start held high gives a new frame after exactly one IDLE cycle
//    following frame_done.
//  - rom_addr/wr_addr never exceed NUM_PIXELS-1. The counters wrap to 0 only via a new frame.
//  - conv_en=0 in IDLE.
// CONFIGURATION
//  GRAY_SUM_EN defined:
//    - frame_sum accumulates wr_data on every wr_en.
//    - It clears at start acceptance and holds after frame_done until the next start.
//    - Width DATAWIDTH+ADDRWIDTH is wide enough that it never overflows.
//  GRAY_SUM_EN undefined: no accumulator logic; frame_sum tied to 0.
// TESTING  (NUM_PIXELS=16, ROM_LAT=1, CONV_LAT=1, L=2, gray_in = model of ROM contents)
//  - Reset mid-frame (RSTn low at pixel 5):
//    all outputs 0 asynchronously; after release, IDLE with busy=0.
//  - start pulse, out_ready=1:
//    rom_addr 0..15 on 16 consecutive cycles; first wr_en 3 cycles after rom_addr=0.
//    wr_addr 0..15 contiguous; frame_done one cycle after the last write; busy=0 next cycle.
//  - out_ready=0 for 4 cycles after the 6th address:
//    rom_addr frozen at 6 and conv_en=0 for 4 cycles.
//    Exactly 16 writes total, addresses 0..15, data matching the model.
//  - abort while rom_addr=7:
//    busy=0 next cycle, no frame_done, no further wr_en.
//    A new start then writes 0..15 with correct data.
//  - start held high for 3 frames:
//    start ignored while busy; frames separated by exactly one IDLE cycle; 48 writes.
//  - GRAY_SUM_EN, gray_in constant 8'h10:
//    frame_sum=256 after frame_done; it clears to 0 at the next start.

Source files
------------

// File: rtl/gray_frame_seq.sv
// Frame sequencer: issues one ROM pixel address per cycle, delay-matches ROM+converter, writes gray frame.
// Latency: address issued in cycle k -> registered frame-buffer write in cycle k+ROM_LAT+CONV_LAT+1.
// Backpressure: out_ready=0 freezes address, valid pipe, write counter and converter (conv_en=0).
// Optional feature macro: GRAY_SUM_EN (frame_sum accumulator); when undefined frame_sum is tied to 0.
module gray_frame_seq #(
    parameter int DATAWIDTH  = 8,
    parameter int ADDRWIDTH  = 18,
    parameter int NUM_PIXELS = 262144,
    parameter int ROM_LAT    = 1,
    parameter int CONV_LAT   = 1
) (
    input  logic                           CLK,
    input  logic                           RSTn,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           out_ready,
    output logic [ADDRWIDTH-1:0]           rom_addr,
    output logic                           conv_en,
    input  logic [DATAWIDTH-1:0]           gray_in,
    output logic                           wr_en,
    output logic [ADDRWIDTH-1:0]           wr_addr,
    output logic [DATAWIDTH-1:0]           wr_data,
    output logic                           busy,
    output logic                           frame_done,
    output logic [DATAWIDTH+ADDRWIDTH-1:0] frame_sum
);

    // Total cycles from address issue to gray sample available at gray_in.
    localparam int L = ROM_LAT + CONV_LAT;
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [L-1:0]           r_vpipe;     // bit i: sample issued i+1 advancing cycles ago is valid
    logic [ADDRWIDTH-1:0]   r_rom_addr;
    logic [ADDRWIDTH-1:0]   r_wcnt;      // address of the next frame-buffer write
    logic [ADDRWIDTH-1:0]   r_wr_addr;
    logic [DATAWIDTH-1:0]   r_wr_data;
    logic                   r_wr_en;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_active;
    logic                   w_adv;
    logic                   w_wr;

    // The ROM/converter pipe only moves while a frame is in flight and the buffer is ready.
    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_adv    = w_active && out_ready;
    // The oldest pipe stage is valid: gray_in carries a pixel that is written this edge.
    assign w_wr     = w_adv && r_vpipe[L-1];

    assign rom_addr   = r_rom_addr;
    assign conv_en    = w_adv;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = r_busy;
    assign frame_done = r_done;

    // Frame FSM with address generation, valid pipe and registered write port.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= S_IDLE;
            r_vpipe    <= '0;
            r_rom_addr <= '0;
            r_wcnt     <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                // Cancel wins over hold: drop everything in flight, no end-of-frame pulse.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_vpipe <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state    <= S_RUN;
                            r_busy     <= 1'b1;
                            r_rom_addr <= '0;
                            r_wcnt     <= '0;
                            r_vpipe    <= '0;
                        end
                    end
                    S_RUN: begin
                        if (out_ready) begin
                            r_vpipe <= {r_vpipe[L-2:0], 1'b1};
                            if (r_rom_addr == LAST_ADDR) begin
                                // Address stays at the last pixel; it never runs past the frame.
                                r_state <= S_DRAIN;
                            end else begin
                                r_rom_addr <= r_rom_addr + ADDRWIDTH'(1);
                            end
                        end
                    end
                    S_DRAIN: begin
                        // Empty pipe: any write registered last edge completes this cycle,
                        // so frame_done lands on the cycle right after the final write.
                        if (r_vpipe == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (out_ready) begin
                            r_vpipe <= {r_vpipe[L-2:0], 1'b0};
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase

                if (w_wr) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_wcnt;
                    r_wr_data <= gray_in;
                    r_wcnt    <= r_wcnt + ADDRWIDTH'(1);
                end
            end
        end
    end

`ifdef GRAY_SUM_EN
    logic [DATAWIDTH+ADDRWIDTH-1:0] r_sum;

    // Running sum of written pixels; cleared when a frame is accepted, held after it ends.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_sum <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_sum <= '0;
        end else if (r_wr_en) begin
            r_sum <= r_sum + {{ADDRWIDTH{1'b0}}, r_wr_data};
        end
    end

    assign frame_sum = r_sum;
`else
    assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_gray_frame_seq.sv
// Bench for gray_frame_seq: 16-pixel frames, L=2, ROM+converter modelled as a conv_en-gated pipe.
// Expected writes are queued when each frame is requested; a monitor pops them on every wr_en.
// Covers reset, plain frame, hold, abort, mid-frame reset, constant-gray sum and back-to-back frames.
module tb_gray_frame_seq;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NP = 16;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          start;
    logic          abort;
    logic          out_ready;
    logic [AW-1:0] rom_addr;
    logic          conv_en;
    logic [DW-1:0] gray_in;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          frame_done;
    logic [DW+AW-1:0] frame_sum;

    gray_frame_seq #(
        .DATAWIDTH (DW),
        .ADDRWIDTH (AW),
        .NUM_PIXELS(NP),
        .ROM_LAT   (1),
        .CONV_LAT  (1)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .start     (start),
        .abort     (abort),
        .out_ready (out_ready),
        .rom_addr  (rom_addr),
        .conv_en   (conv_en),
        .gray_in   (gray_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_sum (frame_sum)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   cyc      = 0;
    int   wr_cnt   = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   last_wr_cyc  = 0;
    int   first_wr_cyc = -1;
    bit   const_mode   = 1'b0;

    // Picture content: either a fixed ramp pattern or a constant gray level.
    function automatic logic [DW-1:0] model(input int a);
        if (const_mode) return 8'h10;
        return 8'(a * 37 + 11);
    endfunction

    // ROM (1 cycle) + converter (1 cycle), both advancing only on conv_en.
    logic [DW-1:0] p0 = '0;
    logic [DW-1:0] p1 = '0;
    always @(posedge CLK) begin
        if (conv_en) begin
            p0 <= model(int'(rom_addr));
            p1 <= p0;
        end
    end
    assign gray_in = p1;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge CLK) begin
        exp_t e;
        if (RSTn && wr_en) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", longint'(wr_addr), e.addr);
                check("wr_data", longint'(wr_data), e.data);
            end
        end
        if (RSTn && frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_addr"}, longint'(rom_addr), 0);
        check({tag, "_conv_en"}, longint'(conv_en), 0);
        check({tag, "_wr_en"}, longint'(wr_en), 0);
        check({tag, "_wr_addr"}, longint'(wr_addr), 0);
        check({tag, "_wr_data"}, longint'(wr_data), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_frame_done"}, longint'(frame_done), 0);
        check({tag, "_frame_sum"}, longint'(frame_sum), 0);
    endtask

    function automatic longint push_frame();
        longint s = 0;
        for (int i = 0; i < NP; i++) begin
            exp_t e;
            e.addr = i;
            e.data = int'(model(i));
            exp_q.push_back(e);
            s += e.data;
        end
        return s;
    endfunction

    // Called at #1 after a posedge with the DUT in IDLE.
    task automatic run_frame(input int hold_at, input int abort_at);
        int     c0;
        int     w0;
        int     d0;
        int     t;
        bit     aborted;
        longint esum;
        esum = push_frame();
        w0 = wr_cnt;
        d0 = done_cnt;
        first_wr_cyc = -1;
        aborted = 1'b0;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        c0 = cyc;
        check("busy_run", longint'(busy), 1);
`ifdef GRAY_SUM_EN
        check("sum_clear_at_start", longint'(frame_sum), 0);
`endif
        for (int i = 0; i < NP; i++) begin
            if (i == abort_at) begin
                check("rom_addr_before_abort", longint'(rom_addr), i);
                abort = 1'b1;
                @(posedge CLK); #1;
                abort = 1'b0;
                check("abort_busy", longint'(busy), 0);
                check("abort_conv_en", longint'(conv_en), 0);
                exp_q.delete();
                repeat (10) @(posedge CLK);
                #1;
                check("abort_no_done", done_cnt - d0, 0);
                check("abort_wr_count", wr_cnt - w0, abort_at - 2);
                aborted = 1'b1;
                break;
            end
            if (i == hold_at) begin
                out_ready = 1'b0;
                #1;
                for (int k = 0; k < 4; k++) begin
                    check("hold_rom_addr", longint'(rom_addr), i);
                    check("hold_conv_en", longint'(conv_en), 0);
                    if (k > 0) check("hold_wr_en", longint'(wr_en), 0);
                    @(posedge CLK); #1;
                end
                out_ready = 1'b1;
            end
            check("rom_addr_seq", longint'(rom_addr), i);
            @(posedge CLK); #1;
        end
        if (!aborted) begin
            t = 0;
            while (done_cnt == d0 && t < 100) begin
                @(posedge CLK); #1;
                t++;
            end
            check("frame_done_count", done_cnt - d0, 1);
            check("busy_after_done", longint'(busy), 0);
            check("conv_en_idle", longint'(conv_en), 0);
            check("done_after_last_wr", done_cyc, last_wr_cyc + 1);
            check("wr_count", wr_cnt - w0, NP);
            check("queue_empty", exp_q.size(), 0);
            check("first_wr_latency", first_wr_cyc - c0, 3);
`ifdef GRAY_SUM_EN
            check("frame_sum", longint'(frame_sum), esum);
            if (const_mode) check("frame_sum_const", longint'(frame_sum), 256);
`else
            check("frame_sum_tied", longint'(frame_sum), 0);
`endif
        end
    endtask

    task automatic reset_mid_frame();
        longint s;
        s = push_frame();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("rst_mid_rom_addr", longint'(rom_addr), 5);
        RSTn = 1'b0;
        #1;
        check_all_zero("rst_async");
        exp_q.delete();
        @(posedge CLK); #1;
        RSTn = 1'b1;
        @(posedge CLK); #1;
        check("rst_release_busy", longint'(busy), 0);
        check("rst_release_conv_en", longint'(conv_en), 0);
        check("rst_release_rom_addr", longint'(rom_addr), 0);
    endtask

    task automatic back_to_back();
        int     w0;
        int     d0;
        int     nd;
        int     idle;
        int     t;
        longint s;
        w0 = wr_cnt;
        d0 = done_cnt;
        for (int f = 0; f < 3; f++) s = push_frame();
        nd = 0;
        idle = 0;
        t = 0;
        start = 1'b1;
        while (nd < 3 && t < 300) begin
            @(posedge CLK); #1;
            t++;
            if (frame_done) begin
                nd++;
                if (nd == 3) start = 1'b0;
            end else if (!busy) begin
                idle++;
            end
        end
        start = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("b2b_done_seen", nd, 3);
        check("b2b_idle_cycles", idle, 2);
        check("b2b_done_count", done_cnt - d0, 3);
        check("b2b_wr_count", wr_cnt - w0, 3 * NP);
        check("b2b_queue_empty", exp_q.size(), 0);
        check("b2b_busy_end", longint'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        RSTn = 1'b1;
        @(posedge CLK); #1;
        check("post_reset_busy", longint'(busy), 0);

        run_frame(-1, -1);
        run_frame(6, -1);
        run_frame(-1, 7);
        run_frame(-1, -1);
        reset_mid_frame();
        const_mode = 1'b1;
        run_frame(-1, -1);
        const_mode = 1'b0;
        run_frame(-1, -1);
        back_to_back();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
